// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants for the in-order LoongArch pipeline.
//   XLEN            datapath width
//   NREG / AW       architectural register count and its address width
//   BYP_*           bypass-source indices; a lower index is a younger stage
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  localparam int BYP_EX  = 0;
  localparam int BYP_MEM = 1;
  localparam int BYP_WB  = 2;

endpackage

// File: rtl/ds_hazard_unit_byp_select.sv
// byp_select: operand resolution for one decode read port.
// Finds the youngest bypass source that writes the requested register and
// either forwards its result or flags a hazard when that result is not yet
// available. With no matching source the scoreboard bit decides the hazard.
// Ports:
//   addr       register read by this port
//   rf_rdata   register-file data for this port
//   pend       scoreboard bit of addr
//   byp_we/byp_waddr/byp_wdata/byp_vld  packed per-source bypass bus
//   data       resolved operand
//   hz         operand cannot be supplied this cycle
module byp_select #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NSRC = 3
) (
  input  logic [AW-1:0]        addr,
  input  logic [XLEN-1:0]      rf_rdata,
  input  logic                 pend,
  input  logic [NSRC-1:0]      byp_we,
  input  logic [NSRC*AW-1:0]   byp_waddr,
  input  logic [NSRC*XLEN-1:0] byp_wdata,
  input  logic [NSRC-1:0]      byp_vld,
  output logic [XLEN-1:0]      data,
  output logic                 hz
);

  logic            hit;
  logic            hit_vld;
  logic [XLEN-1:0] hit_data;

  // Scan oldest to youngest so the youngest matching source is left last.
  always_comb begin
    hit      = 1'b0;
    hit_vld  = 1'b0;
    hit_data = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (byp_we[i] && (byp_waddr[i*AW +: AW] == addr)) begin
        hit      = 1'b1;
        hit_vld  = byp_vld[i];
        hit_data = byp_wdata[i*XLEN +: XLEN];
      end
    end
  end

  // An unready match still returns regfile data so the operand is never X.
  always_comb begin
    data = rf_rdata;
    hz   = 1'b0;
    if (addr == '0) begin
      data = '0;
    end else if (hit) begin
      if (hit_vld) data = hit_data;
      else         hz   = 1'b1;
    end else begin
      hz = pend;
    end
  end

endmodule

// File: rtl/ds_hazard_unit.sv
// ds_hazard_unit: decode-stage operand read and hazard controller.
// Resolves NRD operands over NSRC prioritised bypass sources, tracks
// long-latency destinations in a register scoreboard and bounds the number
// of outstanding long-latency ops, producing ds_ready_go for decode.
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   flush               drop all in-flight ops (scoreboard and counter)
//   rd_addr/rd_need/rf_rdata          per-port read request and regfile data
//   byp_we/byp_waddr/byp_wdata/byp_vld  bypass sources, index 0 youngest
//   ds_valid/ds_we/ds_waddr/ds_long   instruction in decode
//   es_allowin          EX can accept
//   wb_long/wb_waddr    long op retiring this cycle
//   fwd_data            resolved operands
//   ds_ready_go         no hazard (not qualified by ds_valid)
//   pending             scoreboard
//   long_cnt            outstanding long ops
module ds_hazard_unit #(
  parameter int  XLEN     = cpu_pkg::XLEN,
  parameter int  NREG     = cpu_pkg::NREG,
  parameter int  NRD      = 2,
  parameter int  NSRC     = cpu_pkg::BYP_WB + 1,
  parameter int  MAX_LONG = 4,
  localparam int AW       = $clog2(NREG),
  localparam int CW       = $clog2(MAX_LONG + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic [NRD-1:0]       rd_need,
  input  logic [NRD*XLEN-1:0]  rf_rdata,
  input  logic [NSRC-1:0]      byp_we,
  input  logic [NSRC*AW-1:0]   byp_waddr,
  input  logic [NSRC*XLEN-1:0] byp_wdata,
  input  logic [NSRC-1:0]      byp_vld,
  input  logic                 ds_valid,
  input  logic                 ds_we,
  input  logic [AW-1:0]        ds_waddr,
  input  logic                 ds_long,
  input  logic                 es_allowin,
  input  logic                 wb_long,
  input  logic [AW-1:0]        wb_waddr,
  output logic [NRD*XLEN-1:0]  fwd_data,
  output logic                 ds_ready_go,
  output logic [NREG-1:0]      pending,
  output logic [CW-1:0]        long_cnt
);

  import cpu_pkg::*;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LONG);

  logic [NRD-1:0]  hz;
  logic            waw;
  logic            full;
  logic            fire;
  logic            sb_set;
  logic            cnt_inc;
  logic [NREG-1:0] pending_nxt;
  logic [CW-1:0]   long_cnt_nxt;

  for (genvar p = 0; p < NRD; p++) begin : g_port
    byp_select #(
      .XLEN (XLEN),
      .AW   (AW),
      .NSRC (NSRC)
    ) u_byp_select (
      .addr      (rd_addr[p*AW +: AW]),
      .rf_rdata  (rf_rdata[p*XLEN +: XLEN]),
      .pend      (pending[rd_addr[p*AW +: AW]]),
      .byp_we    (byp_we),
      .byp_waddr (byp_waddr),
      .byp_wdata (byp_wdata),
      .byp_vld   (byp_vld),
      .data      (fwd_data[p*XLEN +: XLEN]),
      .hz        (hz[p])
    );
  end

  // A pending destination is still owned by an in-flight long op; writing
  // it again out of order would let the older result land last.
  assign waw  = ds_we && (ds_waddr != '0) && pending[ds_waddr];
  assign full = ds_long && (long_cnt == MAX_CNT);

  assign ds_ready_go = ~((|(hz & rd_need)) | waw | full);
  assign fire        = ds_valid & ds_ready_go & es_allowin;
  assign sb_set      = fire & ds_long & ds_we & (ds_waddr != '0);
  assign cnt_inc     = fire & ds_long;

  // Set is applied after clear so it wins on a same-register collision.
  always_comb begin
    pending_nxt = pending;
    if (wb_long) pending_nxt[wb_waddr] = 1'b0;
    if (sb_set)  pending_nxt[ds_waddr] = 1'b1;
  end

  // Issue and retire in one cycle cancel; a retire with nothing
  // outstanding is ignored rather than wrapping.
  always_comb begin
    long_cnt_nxt = long_cnt;
    if (cnt_inc && !wb_long)
      long_cnt_nxt = long_cnt + CW'(1);
    else if (!cnt_inc && wb_long && (long_cnt != '0))
      long_cnt_nxt = long_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending  <= '0;
      long_cnt <= '0;
    end else if (flush) begin
      pending  <= '0;
      long_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      long_cnt <= long_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ds_hazard_unit.sv
module tb_ds_hazard_unit;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int NRD      = 2;
  localparam int NSRC     = 3;
  localparam int MAX_LONG = 4;
  localparam int CW       = 3;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 flush;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD-1:0]       rd_need;
  logic [NRD*XLEN-1:0]  rf_rdata;
  logic [NSRC-1:0]      byp_we;
  logic [NSRC*AW-1:0]   byp_waddr;
  logic [NSRC*XLEN-1:0] byp_wdata;
  logic [NSRC-1:0]      byp_vld;
  logic                 ds_valid;
  logic                 ds_we;
  logic [AW-1:0]        ds_waddr;
  logic                 ds_long;
  logic                 es_allowin;
  logic                 wb_long;
  logic [AW-1:0]        wb_waddr;
  logic [NRD*XLEN-1:0]  fwd_data;
  logic                 ds_ready_go;
  logic [NREG-1:0]      pending;
  logic [CW-1:0]        long_cnt;

  always #5 clk = ~clk;

  ds_hazard_unit #(
    .XLEN (XLEN), .NREG (NREG), .NRD (NRD), .NSRC (NSRC), .MAX_LONG (MAX_LONG)
  ) dut (
    .clk (clk), .resetn (resetn), .flush (flush),
    .rd_addr (rd_addr), .rd_need (rd_need), .rf_rdata (rf_rdata),
    .byp_we (byp_we), .byp_waddr (byp_waddr), .byp_wdata (byp_wdata), .byp_vld (byp_vld),
    .ds_valid (ds_valid), .ds_we (ds_we), .ds_waddr (ds_waddr), .ds_long (ds_long),
    .es_allowin (es_allowin), .wb_long (wb_long), .wb_waddr (wb_waddr),
    .fwd_data (fwd_data), .ds_ready_go (ds_ready_go), .pending (pending), .long_cnt (long_cnt)
  );

  int checks   = 0;
  int failures = 0;
  bit check_en = 0;
  bit allow_uf = 0;

  // Model state: set of registers owned by long ops, and their count.
  logic [NREG-1:0] pend_m = '0;
  int              cnt_m  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_eval(output logic [NRD*XLEN-1:0] f, output logic rdy);
    int a;
    int src;
    bit found;
    bit any_hz;
    bit waw;
    bit full;
    f      = '0;
    any_hz = 0;
    for (int p = 0; p < NRD; p++) begin
      a     = int'(rd_addr[p*AW +: AW]);
      found = 0;
      src   = 0;
      if (a != 0) begin
        for (int i = 0; i < NSRC; i++)
          if (!found && byp_we[i] && int'(byp_waddr[i*AW +: AW]) == a) begin
            found = 1;
            src   = i;
          end
        if (found && byp_vld[src]) begin
          f[p*XLEN +: XLEN] = byp_wdata[src*XLEN +: XLEN];
        end else begin
          f[p*XLEN +: XLEN] = rf_rdata[p*XLEN +: XLEN];
          if ((found || pend_m[a]) && rd_need[p]) any_hz = 1;
        end
      end
    end
    waw  = ds_we && (ds_waddr != 0) && pend_m[ds_waddr];
    full = ds_long && (cnt_m == MAX_LONG);
    rdy  = !(any_hz || waw || full);
  endfunction

  always @(posedge clk) begin : model
    logic [NRD*XLEN-1:0] f;
    logic r;
    bit   fire;
    bit   set;
    m_eval(f, r);
    fire = ds_valid && r && es_allowin;
    if (!resetn || flush) begin
      pend_m = '0;
      cnt_m  = 0;
    end else begin
      set = fire && ds_long && ds_we && (ds_waddr != 0);
      if (check_en && set && wb_long && (wb_waddr == ds_waddr)) begin
        checks++;
        failures++;
        $display("FAIL protocol_set_clear_same_reg reg=%0d at %0t", ds_waddr, $time);
      end
      if (check_en && wb_long && cnt_m == 0 && !allow_uf) begin
        checks++;
        failures++;
        $display("FAIL protocol_retire_underflow count=0 at %0t", $time);
      end
      if (wb_long) pend_m[wb_waddr] = 1'b0;
      if (set)     pend_m[ds_waddr] = 1'b1;
      cnt_m = cnt_m + ((fire && ds_long) ? 1 : 0) - (wb_long ? 1 : 0);
      if (cnt_m < 0) cnt_m = 0;
    end
  end

  always @(negedge clk) begin : compare
    logic [NRD*XLEN-1:0] f;
    logic r;
    if (check_en) begin
      m_eval(f, r);
      check("cyc_fwd_data", 64'(fwd_data), 64'(f));
      check("cyc_ds_ready_go", 64'(ds_ready_go), 64'(r));
      check("cyc_pending", 64'(pending), 64'(pend_m));
      check("cyc_long_cnt", 64'(long_cnt), 64'(cnt_m));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    resetn = 1; flush = 0; rd_addr = '0; rd_need = '0; rf_rdata = '0;
    byp_we = '0; byp_waddr = '0; byp_wdata = '0; byp_vld = '0;
    ds_valid = 0; ds_we = 0; ds_waddr = '0; ds_long = 0; es_allowin = 0;
    wb_long = 0; wb_waddr = '0;
  endtask

  task automatic src(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic v);
    byp_we[i] = 1'b1;
    byp_waddr[i*AW +: AW] = a;
    byp_wdata[i*XLEN +: XLEN] = d;
    byp_vld[i] = v;
  endtask

  task automatic dec(input logic [AW-1:0] a, input logic lng, input logic we);
    ds_valid = 1; ds_we = we; ds_waddr = a; ds_long = lng; es_allowin = 1;
  endtask

  initial begin
    idle();
    resetn = 0;
    tick(); tick();
    check_en = 1;
    #1;
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_long_cnt", 64'(long_cnt), 64'h0);
    check("rst_ready", 64'(ds_ready_go), 64'h1);
    resetn = 1;
    tick();

    rd_addr[0 +: AW] = 5; rd_addr[AW +: AW] = 0;
    rf_rdata = {32'h22, 32'h11};
    #1;
    check("rf_and_r0", 64'(fwd_data), 64'h0000_0000_0000_0011);
    check("rf_ready", 64'(ds_ready_go), 64'h1);

    tick();
    src(0, 5, 32'hAAAA, 1); src(2, 5, 32'hBBBB, 1); rd_need = 2'b01;
    #1;
    check("ex_over_wb", 64'(fwd_data[XLEN-1:0]), 64'hAAAA);
    tick();
    byp_vld[0] = 0;
    #1;
    check("ex_unready_stall", 64'(ds_ready_go), 64'h0);
    check("ex_unready_rf", 64'(fwd_data[XLEN-1:0]), 64'h11);
    tick();
    rd_need = 2'b00;
    #1;
    check("ex_unready_unneeded", 64'(ds_ready_go), 64'h1);

    tick(); idle();
    rd_addr[0 +: AW] = 5; rd_need = 2'b11; rf_rdata = {32'h22, 32'h11};
    src(1, 5, 32'hCCCC, 1); src(2, 5, 32'hBBBB, 1); src(0, 0, 32'hDEAD, 1);
    #1;
    check("mem_over_wb", 64'(fwd_data[XLEN-1:0]), 64'hCCCC);
    check("r0_no_bypass", 64'(fwd_data[2*XLEN-1:XLEN]), 64'h0);

    tick(); idle(); dec(7, 1, 1);
    tick(); idle();
    #1;
    check("long_set_pending", 64'(pending), 64'h80);
    check("long_cnt_one", 64'(long_cnt), 64'h1);
    rd_addr[0 +: AW] = 7; rd_need = 2'b01; rf_rdata[XLEN-1:0] = 32'h11;
    #1;
    check("pending_stall", 64'(ds_ready_go), 64'h0);
    tick();
    wb_long = 1; wb_waddr = 7; src(2, 7, 32'h77, 1);
    #1;
    check("wb_bypass_fwd", 64'(fwd_data[XLEN-1:0]), 64'h77);
    check("wb_bypass_ready", 64'(ds_ready_go), 64'h1);
    tick(); idle();
    #1;
    check("retire_pending", 64'(pending), 64'h0);
    check("retire_cnt", 64'(long_cnt), 64'h0);

    for (int k = 1; k <= 4; k++) begin
      dec(AW'(k), 1, 1);
      tick();
    end
    idle();
    #1;
    check("cnt_max", 64'(long_cnt), 64'h4);
    check("pending_r1_r4", 64'(pending), 64'h1E);
    dec(5, 1, 1);
    #1;
    check("full_stall", 64'(ds_ready_go), 64'h0);
    tick();
    wb_long = 1; wb_waddr = 1;
    #1;
    check("full_while_retire", 64'(ds_ready_go), 64'h0);
    tick();
    wb_long = 0;
    #1;
    check("cnt_after_retire", 64'(long_cnt), 64'h3);
    check("full_released", 64'(ds_ready_go), 64'h1);
    wb_long = 1; wb_waddr = 2;
    tick(); idle();
    #1;
    check("fire_and_retire_cnt", 64'(long_cnt), 64'h3);
    check("pending_r3_r5", 64'(pending), 64'h38);
    for (int k = 3; k <= 5; k++) begin
      wb_long = 1; wb_waddr = AW'(k);
      tick();
    end
    idle();

    dec(9, 1, 1);
    tick(); idle(); dec(9, 0, 1);
    #1;
    check("waw_stall", 64'(ds_ready_go), 64'h0);
    wb_long = 1; wb_waddr = 9;
    #1;
    check("waw_stall_retire_cycle", 64'(ds_ready_go), 64'h0);
    tick();
    wb_long = 0;
    #1;
    check("waw_release", 64'(ds_ready_go), 64'h1);
    tick(); idle();

    allow_uf = 1; wb_long = 1; wb_waddr = 3;
    tick(); idle(); allow_uf = 0;
    #1;
    check("underflow_hold", 64'(long_cnt), 64'h0);

    dec(0, 1, 1);
    tick(); idle();
    #1;
    check("r0_long_not_pending", 64'(pending), 64'h0);
    check("r0_long_counted", 64'(long_cnt), 64'h1);
    wb_long = 1; wb_waddr = 0;
    tick(); idle();

    for (int k = 11; k <= 13; k++) begin
      dec(AW'(k), 1, 1);
      tick();
    end
    idle();
    #1;
    check("pre_flush_cnt", 64'(long_cnt), 64'h3);
    dec(14, 1, 1); flush = 1; wb_long = 1; wb_waddr = 11;
    tick(); idle();
    #1;
    check("flush_pending", 64'(pending), 64'h0);
    check("flush_cnt", 64'(long_cnt), 64'h0);

    for (int k = 11; k <= 13; k++) begin
      dec(AW'(k), 1, 1);
      tick();
    end
    idle();
    dec(14, 1, 1); resetn = 0;
    tick(); idle();
    #1;
    check("midreset_pending", 64'(pending), 64'h0);
    check("midreset_cnt", 64'(long_cnt), 64'h0);

    tick(); tick();
    check_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
